// File: rtl/atb_protocol_checker.sv
// atb_protocol_checker: passive ATB link monitor.
// Flags data/flush/ID rule violations (C0..C5) through sticky bits, a
// one-cycle error pulse and saturating error/transfer counters.
// Optional build macro ATB_CHK_STABILITY_EN adds the C3 stall-stability
// check and its payload capture registers.
module atb_protocol_checker #(
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned BYTES_W       = $clog2(DATA_W/8),
   parameter int unsigned CNT_W         = 16,
   parameter int unsigned FLUSH_TIMEOUT = 1024
) (
   input  logic               atclk,
   input  logic               atresetn,
   input  logic               atclken,
   input  logic [DATA_W-1:0]  atdata,
   input  logic [BYTES_W-1:0] atbytes,
   input  logic [6:0]         atid,
   input  logic               atvalid,
   input  logic               atready,
   input  logic               afvalid,
   input  logic               afready,
   input  logic               clr,
   output logic [5:0]         err_sticky,
   output logic               err_pulse,
   output logic [CNT_W-1:0]   err_count,
   output logic [CNT_W-1:0]   xfer_count
);

   localparam int unsigned      TO_W    = $clog2(FLUSH_TIMEOUT + 1);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(FLUSH_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {FL_IDLE, FL_WAIT, FL_DONE} fl_e;

   logic transfer, flush_hs;
   logic c0, c1, c2, c3, c4, c5;
   logic [5:0] viol;
   logic       any_viol;

   fl_e             fl_q, fl_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            hs_q, hs_d;
   logic [5:0]       sticky_q, sticky_d;
   logic             pulse_q, pulse_d;
   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
   logic [CNT_W-1:0] err_base, xfer_base;

   assign transfer = atvalid && atready;
   assign flush_hs = afvalid && afready;

   // Stateless checks evaluated on the current sample
   always_comb begin
      c0 = transfer && (atdata == '0);
      c1 = hs_q && afvalid;
      c2 = transfer && (((atid >= 7'h70) && (atid <= 7'h7C)) ||
                        (atid == 7'h7E) || (atid == 7'h7F));
      c4 = afready && !afvalid;
   end

`ifdef ATB_CHK_STABILITY_EN
   typedef enum logic {ST_IDLE, ST_STALL} st_e;

   st_e                st_q, st_d;
   logic [DATA_W-1:0]  cap_data_q, cap_data_d;
   logic [BYTES_W-1:0] cap_bytes_q, cap_bytes_d;
   logic [6:0]         cap_id_q, cap_id_d;

   // Stall FSM: payload must stay put while atvalid waits for atready
   always_comb begin
      st_d        = st_q;
      cap_data_d  = cap_data_q;
      cap_bytes_d = cap_bytes_q;
      cap_id_d    = cap_id_q;
      c3          = 1'b0;
      case (st_q)
         ST_IDLE: begin
            if (atvalid && !atready) begin
               st_d        = ST_STALL;
               cap_data_d  = atdata;
               cap_bytes_d = atbytes;
               cap_id_d    = atid;
            end
         end
         ST_STALL: begin
            if (!atvalid || (atdata != cap_data_q) ||
                (atbytes != cap_bytes_q) || (atid != cap_id_q))
               c3 = 1'b1;
            if (!atvalid || atready) begin
               st_d = ST_IDLE;
            end else begin
               // still stalled: track the latest payload so one change flags once
               cap_data_d  = atdata;
               cap_bytes_d = atbytes;
               cap_id_d    = atid;
            end
         end
         default: st_d = ST_IDLE;
      endcase
   end

   // Stall FSM state and capture registers
   always_ff @(posedge atclk or negedge atresetn) begin
      if (!atresetn) begin
         st_q        <= ST_IDLE;
         cap_data_q  <= '0;
         cap_bytes_q <= '0;
         cap_id_q    <= '0;
      end else if (atclken) begin
         st_q        <= st_d;
         cap_data_q  <= cap_data_d;
         cap_bytes_q <= cap_bytes_d;
         cap_id_q    <= cap_id_d;
      end
   end
`else
   logic unused_bytes;
   assign unused_bytes = ^atbytes;
   assign c3 = 1'b0;
`endif

   // Flush FSM: afvalid must not wait for afready longer than FLUSH_TIMEOUT
   always_comb begin
      fl_d     = fl_q;
      to_cnt_d = to_cnt_q;
      c5       = 1'b0;
      case (fl_q)
         FL_IDLE: begin
            if (afvalid && !afready) begin
               fl_d     = FL_WAIT;
               to_cnt_d = TO_W'(1);
            end
         end
         FL_WAIT: begin
            if (flush_hs || !afvalid) begin
               fl_d     = FL_IDLE;
               to_cnt_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
               if (to_cnt_d == TO_LAST) begin
                  c5   = 1'b1;
                  fl_d = FL_DONE;
               end
            end
         end
         FL_DONE: begin
            if (flush_hs || !afvalid) begin
               fl_d     = FL_IDLE;
               to_cnt_d = '0;
            end
         end
         default: begin
            fl_d     = FL_IDLE;
            to_cnt_d = '0;
         end
      endcase
   end

   // Status and counter next-state; clr zeroes first, then this cycle's events apply
   always_comb begin
      viol       = {c5, c4, c3, c2, c1, c0};
      any_viol   = |viol;
      hs_d       = flush_hs;
      sticky_d   = (clr ? 6'b0 : sticky_q) | viol;
      pulse_d    = any_viol;
      err_base   = clr ? '0 : err_cnt_q;
      xfer_base  = clr ? '0 : xfer_cnt_q;
      err_cnt_d  = (any_viol && (err_base != CNT_MAX)) ? err_base + 1'b1 : err_base;
      xfer_cnt_d = (transfer && (xfer_base != CNT_MAX)) ? xfer_base + 1'b1 : xfer_base;
   end

   // Flush FSM and status registers, advancing only on qualified edges
   always_ff @(posedge atclk or negedge atresetn) begin
      if (!atresetn) begin
         fl_q       <= FL_IDLE;
         to_cnt_q   <= '0;
         hs_q       <= 1'b0;
         sticky_q   <= '0;
         pulse_q    <= 1'b0;
         err_cnt_q  <= '0;
         xfer_cnt_q <= '0;
      end else if (atclken) begin
         fl_q       <= fl_d;
         to_cnt_q   <= to_cnt_d;
         hs_q       <= hs_d;
         sticky_q   <= sticky_d;
         pulse_q    <= pulse_d;
         err_cnt_q  <= err_cnt_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   assign err_sticky = sticky_q;
   assign err_pulse  = pulse_q;
   assign err_count  = err_cnt_q;
   assign xfer_count = xfer_cnt_q;

endmodule

// File: doc/atb_protocol_checker.md
# atb_protocol_checker

Synthesizable, parametrised ATB protocol checker. Sits passively on any ATB link between trace source and sink, samples the link each qualified clock, and reports violations through sticky status bits, a one-cycle error pulse and saturating counters. Covers the data, flush and ID rules we already enforce, and adds payload-stability, spurious-flush-ack and flush-timeout checks.

## Interface
- DATA_W, 32: atdata width; legal 32, 64, 128.
- BYTES_W, $clog2(DATA_W/8): atbytes width (derived; do not override).
- CNT_W, 16: width of err_count and xfer_count.
- FLUSH_TIMEOUT, 1024: maximum qualified cycles afvalid may stay high without afready; legal 2..2^20.

- atclk  in  1  clock.
- atresetn  in  1  reset; asynchronous, active-low.
- atclken  in  1  clock enable; all sampling, state and counters advance only when high.
- atdata  in  DATA_W  trace data.
- atbytes  in  BYTES_W  valid bytes minus one.
- atid  in  7  trace source ID.
- atvalid, atready  in  1 each  transfer handshake.
- afvalid, afready  in  1 each  flush handshake.
- clr  in  1  synchronous clear of status and counters (qualified by atclken).
- err_sticky  out  6  per-check sticky flags, bit n = check Cn.
- err_pulse  out  1  high for one qualified cycle after any violation.
- err_count  out  CNT_W  qualified cycles with at least one violation, saturating.
- xfer_count  out  CNT_W  completed transfers (atvalid&&atready), saturating.

## Operation
- Transfer = atvalid&&atready on a qualified edge. Flush handshake = afvalid&&afready.
- C0: transfer with atdata == 0.
- C1: afvalid still high on the qualified cycle after a flush handshake.
- C2: transfer with atid in 0x70..0x7C, 0x7E or 0x7F.
- C3: stall stability. FSM IDLE/STALL. IDLE→STALL when atvalid&&!atready; capture atdata, atbytes, atid. In STALL: violation if atvalid drops, or any captured field differs; STALL→IDLE on transfer or on atvalid drop. Violation while stalling leaves FSM in STALL with recaptured payload.
- C4: afready high while afvalid low.
- C5: flush timeout. FSM FL_IDLE/FL_WAIT/FL_DONE. FL_IDLE→FL_WAIT on afvalid&&!afready, counter loads 1. FL_WAIT: counter increments each qualified cycle; reaching FLUSH_TIMEOUT flags C5 once and enters FL_DONE. FL_WAIT or FL_DONE→FL_IDLE on flush handshake or afvalid drop. Flush handshake in same cycle afvalid rises → stays FL_IDLE.
- Multiple checks failing in one cycle: all corresponding bits set; err_count +1 only.
- Counters saturate at 2^CNT_W-1; no wrap.
- clr: clears err_sticky, err_count, xfer_count; does not reset FSMs. clr with a simultaneous violation/transfer: cleared value then applied, i.e. sticky shows new bits, counts become 1.
- atclken low: inputs ignored, all state and outputs hold, err_pulse holds its value (consumers qualify with atclken).

## Timing
- All outputs registered; reset values all zero, FSMs in IDLE/FL_IDLE, timeout counter 0.
- Violation sampled at qualified edge N → err_sticky bit, err_pulse, err_count update visible after edge N; err_pulse drops after next qualified edge unless a new violation.
- C3 first checkable one qualified cycle after stall begins.
- C5 flags exactly FLUSH_TIMEOUT qualified cycles after afvalid first sampled high without afready.
- Reset asserted mid-stall or mid-flush: immediate return to reset state; no violation attributed to partial sequences after release.

## Configuration
- ATB_CHK_STABILITY_EN: defined → C3 logic and payload capture registers (DATA_W+BYTES_W+7 flops) built. Undefined → no capture registers, err_sticky[3] constant 0, C3 never contributes to err_pulse/err_count; all other checks unchanged.

## Test plan
- Reset, then 10 transfers of atdata=0x1, atid=0x10 → xfer_count=10, err_sticky=0, err_pulse never high.
- Transfer with atdata=0, atid=0x7E → err_sticky=6'b000101, err_count=1, one-cycle err_pulse.
- atvalid high, atready low 3 cycles, atdata changes 0xA→0xB on cycle 2 → err_sticky[3]=1 with macro, 0 without.
- afvalid high, afready never, FLUSH_TIMEOUT=8 → err_sticky[5] set after 8th qualified cycle, err_count=1 only; then afready while afvalid low → bit 4 set, count=2.
- Flush handshake, afvalid held one more cycle → C1; toggle atclken low for 5 cycles mid-flush → timeout count frozen.
- err_count preloaded to saturation with CNT_W=4 (16 violating cycles) → stays 15; clr with simultaneous violation → count=1.
